// File: rtl/vga_pixel_source.sv
// vga_pixel_source: fetches framebuffer words into a show-ahead pixel FIFO; the head appears on pixel_color with zero latency.
// Backpressure: new reads issue only while buffered + in-flight pixels < FIFO_DEPTH; VGA_PIXEL_SOURCE_UNDERFLOW_COUNT_EN adds underflow_count.
module vga_pixel_source #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              vsync,
    output logic [23:0]       pixel_color,
    input  logic              pixel_taken,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              underflow
`ifdef VGA_PIXEL_SOURCE_UNDERFLOW_COUNT_EN
    ,
    output logic [15:0]       underflow_count
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [18:0] LAST_IDX  = 19'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0] OCC_LIMIT = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [18:0]       pix_idx_q, pix_idx_d;
    logic              mem_req_q, mem_req_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [23:0]       fifo_mem_q [FIFO_DEPTH];
    logic [CW:0]       occupancy;
    logic              fifo_empty, ack_fire, do_pop, do_push;
    logic              unused_rdata_hi;

    assign fifo_empty      = (count_q == '0);
    assign ack_fire        = mem_req_q & mem_ack;
    assign do_pop          = pixel_taken & ~fifo_empty;
    assign do_push         = mem_rvalid & (discard_q == '0);
    assign pixel_color     = fifo_empty ? 24'h000000 : fifo_mem_q[rd_ptr_q];
    assign underflow       = pixel_taken & fifo_empty;
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign unused_rdata_hi = ^mem_rdata[31:24];

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        pix_idx_d  = pix_idx_q;
        mem_req_d  = mem_req_q & ~ack_fire;
        outst_d    = outst_q + CW'(ack_fire) - CW'(mem_rvalid);
        discard_d  = discard_q - CW'(mem_rvalid && (discard_q != '0));
        rd_ptr_d   = rd_ptr_q + PW'(do_pop);
        wr_ptr_d   = wr_ptr_q + PW'(do_push);
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        occupancy  = '0;

        if (vsync) begin
            // Everything still in flight after this cycle belongs to the old frame.
            state_d   = FETCH;
            base_d    = fb_base;
            pix_idx_d = '0;
            mem_req_d = 1'b0;
            discard_d = outst_d;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (ack_fire) begin
                pix_idx_d = pix_idx_q + 19'd1;
                if (pix_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            occupancy = {1'b0, count_d} + {1'b0, outst_d};
            if (state_d == FETCH && !mem_req_d && occupancy < OCC_LIMIT) begin
                mem_req_d  = 1'b1;
                mem_addr_d = base_q + ADDR_W'({pix_idx_d, 2'b00});
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            mem_addr_q <= '0;
            pix_idx_q  <= '0;
            mem_req_q  <= 1'b0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            pix_idx_q  <= pix_idx_d;
            mem_req_q  <= mem_req_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= mem_rdata[23:0];
        end
    end

`ifdef VGA_PIXEL_SOURCE_UNDERFLOW_COUNT_EN
    logic [15:0] uf_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uf_cnt_q <= '0;
        end else if (underflow && uf_cnt_q != 16'hFFFF) begin
            uf_cnt_q <= uf_cnt_q + 16'd1;
        end
    end

    assign underflow_count = uf_cnt_q;
`endif

    // The issue rule bounds buffered + in-flight pixels, so these can only fire on a design bug.
    push_never_full: assert property (@(posedge clk) disable iff (reset)
        !(do_push && count_q == DEPTH_C));
    rvalid_has_request: assert property (@(posedge clk) disable iff (reset)
        mem_rvalid |-> (outst_q != '0));

endmodule
